// File: rtl/tpu_ctrl_pkg.sv
// rtl/tpu_ctrl_pkg.sv - shared types and width helpers for the TPU control blocks
package tpu_ctrl_pkg;

   typedef enum logic [2:0] {
      FILL_IDLE,
      FILL_ISSUE,
      FILL_WAIT,
      FILL_LOADED,
      FILL_DRAIN
   } fill_state_t;

   localparam int DEFAULT_FIFO_WIDTH = 16;
   localparam int ROW_COUNT_WIDTH    = $clog2(DEFAULT_FIFO_WIDTH) + 1;

   function automatic int row_count_width(input int fifo_width);
      return $clog2(fifo_width) + 1;
   endfunction

   function automatic int row_bus_width(input int fifo_width, input int data_width);
      return fifo_width * data_width;
   endfunction

endpackage

// File: rtl/valid_delay_line.sv
// rtl/valid_delay_line.sv - DEPTH-stage {valid, real} shift register with synchronous clear
module valid_delay_line #(
   parameter int DEPTH = 1
) (
   input  logic clk,
   input  logic i_clear,
   input  logic i_valid,
   input  logic i_real,
   output logic o_valid,
   output logic o_real,
   output logic o_pending
);

   localparam logic [DEPTH-1:0] OUT_MASK = DEPTH'(1) << (DEPTH - 1);

   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] r_real;

   always_ff @(posedge clk) begin
      if (i_clear) begin
         r_valid <= '0;
         r_real  <= '0;
      end else begin
         r_valid[0] <= i_valid;
         r_real[0]  <= i_real;
         for (int i = 1; i < DEPTH; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_real[i]  <= r_real[i-1];
         end
      end
   end

   assign o_valid = r_valid[DEPTH-1];
   assign o_real  = r_real[DEPTH-1];
   // entries still in flight behind the one currently at the output
   assign o_pending = |(r_valid & ~OUT_MASK);

endmodule

// File: rtl/weight_fifo_fill.sv
// rtl/weight_fifo_fill.sv - weight FIFO fill controller; WEIGHT_FILL_REVERSE_EN pushes tile rows last-first
module weight_fifo_fill
   import tpu_ctrl_pkg::*;
#(
   parameter int FIFO_WIDTH  = 16,
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 8,
   parameter int MEM_LATENCY = 1
) (
   input  logic                                            clk,
   input  logic                                            reset,
   input  logic                                            i_start,
   input  logic [ADDR_WIDTH-1:0]                           i_base_addr,
   input  logic [row_count_width(FIFO_WIDTH)-1:0]          i_num_rows,
   output logic                                            o_mem_rd_en,
   output logic [ADDR_WIDTH-1:0]                           o_mem_addr,
   input  logic [row_bus_width(FIFO_WIDTH, DATA_WIDTH)-1:0] i_mem_rd_data,
   output logic [FIFO_WIDTH-1:0]                           o_fifo_wr_en,
   output logic [row_bus_width(FIFO_WIDTH, DATA_WIDTH)-1:0] o_fifo_wr_data,
   input  logic                                            i_drain_start,
   input  logic                                            i_drain_done,
   output logic                                            o_loaded,
   output logic                                            o_busy
);

   localparam int RCW = row_count_width(FIFO_WIDTH);
   localparam int KW  = RCW - 1;
   localparam logic [KW-1:0]  K_LAST = KW'(FIFO_WIDTH - 1);
   localparam logic [RCW-1:0] N_MAX  = RCW'(FIFO_WIDTH);

   fill_state_t           r_state;
   fill_state_t           w_next;
   logic [KW-1:0]         r_k;
   logic [RCW-1:0]        r_n;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [ADDR_WIDTH-1:0] r_last_addr;
   logic                  w_issue;
   logic                  w_real_slot;
   logic                  w_push;
   logic                  w_push_real;
   logic                  w_pending;
   logic [RCW-1:0]        w_offset;
   logic [ADDR_WIDTH-1:0] w_slot_addr;

   assign w_issue     = (r_state == FILL_ISSUE);
   assign w_real_slot = ({1'b0, r_k} < r_n);

`ifdef WEIGHT_FILL_REVERSE_EN
   assign w_offset = r_n - RCW'(1) - {1'b0, r_k};
`else
   assign w_offset = {1'b0, r_k};
`endif
   assign w_slot_addr = r_base + ADDR_WIDTH'(w_offset);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= FILL_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         FILL_IDLE:   if (i_start)              w_next = FILL_ISSUE;
         FILL_ISSUE:  if (r_k == K_LAST)        w_next = FILL_WAIT;
         FILL_WAIT:   if (!w_pending)           w_next = FILL_LOADED;
         FILL_LOADED: if (i_drain_start)        w_next = FILL_DRAIN;
         FILL_DRAIN:  if (i_drain_done)         w_next = FILL_IDLE;
         default:                               w_next = FILL_IDLE;
      endcase
   end

   always_comb begin
      o_mem_rd_en = 1'b0;
      o_loaded    = 1'b0;
      o_busy      = 1'b1;
      case (r_state)
         FILL_IDLE:   o_busy      = 1'b0;
         FILL_ISSUE:  o_mem_rd_en = w_real_slot;
         FILL_LOADED: o_loaded    = 1'b1;
         default:     ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_k         <= '0;
         r_n         <= '0;
         r_base      <= '0;
         r_last_addr <= '0;
      end else begin
         if (r_state == FILL_IDLE && i_start) begin
            r_k    <= '0;
            r_base <= i_base_addr;
            r_n    <= (i_num_rows > N_MAX) ? N_MAX : i_num_rows;
         end else if (w_issue) begin
            r_k <= r_k + KW'(1);
         end
         if (o_mem_rd_en) begin
            r_last_addr <= w_slot_addr;
         end
      end
   end

   // padding slots keep the address bus parked on the last real read
   assign o_mem_addr = o_mem_rd_en ? w_slot_addr : r_last_addr;

   valid_delay_line #(
      .DEPTH(MEM_LATENCY)
   ) u_delay (
      .clk      (clk),
      .i_clear  (reset),
      .i_valid  (w_issue),
      .i_real   (w_issue & w_real_slot),
      .o_valid  (w_push),
      .o_real   (w_push_real),
      .o_pending(w_pending)
   );

   assign o_fifo_wr_en   = {FIFO_WIDTH{w_push}};
   assign o_fifo_wr_data = (w_push && w_push_real) ? i_mem_rd_data : '0;

endmodule

// File: tb/tb_weight_fifo_fill.sv
// tb/tb_weight_fifo_fill.sv - randomized self-checking bench for weight_fifo_fill at latencies 1 and 3
module tb_weight_fifo_fill;

   localparam int FW   = 16;
   localparam int DW   = 8;
   localparam int AW   = 8;
   localparam int RCW  = $clog2(FW) + 1;
   localparam int RW   = FW * DW;
   localparam int LAT0 = 1;
   localparam int LAT1 = 3;

   logic            clk = 1'b0;
   logic            rst         [2];
   logic            start       [2];
   logic [AW-1:0]   base_a      [2];
   logic [RCW-1:0]  nrows       [2];
   logic            drain_start [2];
   logic            drain_done  [2];
   logic            rd_en       [2];
   logic [AW-1:0]   addr        [2];
   logic [RW-1:0]   rd_data     [2];
   logic [FW-1:0]   wr_en       [2];
   logic [RW-1:0]   wr_data     [2];
   logic            loaded      [2];
   logic            busy        [2];

   logic [RW-1:0]   mem [256];
   logic [AW-1:0]   h0;
   logic [AW-1:0]   h1 [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      h0    <= addr[0];
      h1[0] <= addr[1];
      h1[1] <= h1[0];
      h1[2] <= h1[1];
   end
   assign rd_data[0] = mem[h0];
   assign rd_data[1] = mem[h1[2]];

   weight_fifo_fill #(.FIFO_WIDTH(FW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT0)) u_dut_l1 (
      .clk(clk), .reset(rst[0]), .i_start(start[0]), .i_base_addr(base_a[0]), .i_num_rows(nrows[0]),
      .o_mem_rd_en(rd_en[0]), .o_mem_addr(addr[0]), .i_mem_rd_data(rd_data[0]),
      .o_fifo_wr_en(wr_en[0]), .o_fifo_wr_data(wr_data[0]),
      .i_drain_start(drain_start[0]), .i_drain_done(drain_done[0]),
      .o_loaded(loaded[0]), .o_busy(busy[0])
   );

   weight_fifo_fill #(.FIFO_WIDTH(FW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(LAT1)) u_dut_l3 (
      .clk(clk), .reset(rst[1]), .i_start(start[1]), .i_base_addr(base_a[1]), .i_num_rows(nrows[1]),
      .o_mem_rd_en(rd_en[1]), .o_mem_addr(addr[1]), .i_mem_rd_data(rd_data[1]),
      .o_fifo_wr_en(wr_en[1]), .o_fifo_wr_data(wr_data[1]),
      .i_drain_start(drain_start[1]), .i_drain_done(drain_done[1]),
      .o_loaded(loaded[1]), .o_busy(busy[1])
   );

   task automatic check_eq(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int lat_of(input int d);
      return (d == 0) ? LAT0 : LAT1;
   endfunction

   // address of tile slot k for a tile of n real rows starting at base
   function automatic logic [AW-1:0] slot_addr(input int base, input int n, input int k);
      int off;
`ifdef WEIGHT_FILL_REVERSE_EN
      off = n - 1 - k;
`else
      off = k;
`endif
      return AW'((base + off) % (1 << AW));
   endfunction

   task automatic check_cycle(input int d, input int rel, input int base, input int n);
      int            lat;
      int            slot;
      logic          exp_rd;
      logic          exp_push;
      logic [FW-1:0] exp_en;
      logic [RW-1:0] exp_data;
      lat      = lat_of(d);
      slot     = rel - 1 - lat;
      exp_rd   = (rel >= 1) && (rel <= FW) && (rel - 1 < n);
      exp_push = (rel >= 1 + lat) && (rel <= FW + lat);
      exp_en   = exp_push ? {FW{1'b1}} : {FW{1'b0}};
      exp_data = '0;
      if (exp_push && slot < n) exp_data = mem[slot_addr(base, n, slot)];
      check_eq($sformatf("d%0d r%0d rd_en", d, rel), rd_en[d], exp_rd);
      if (exp_rd) check_eq($sformatf("d%0d r%0d addr", d, rel), addr[d], slot_addr(base, n, rel - 1));
      check_eq($sformatf("d%0d r%0d wr_en", d, rel), wr_en[d], exp_en);
      check_eq($sformatf("d%0d r%0d wr_data", d, rel), wr_data[d], exp_data);
      check_eq($sformatf("d%0d r%0d loaded", d, rel), loaded[d], rel >= FW + lat + 1);
      check_eq($sformatf("d%0d r%0d busy", d, rel), busy[d], 1'b1);
   endtask

   task automatic check_quiet(input int d, input string tag, input logic exp_busy);
      check_eq($sformatf("d%0d %s rd_en", d, tag), rd_en[d], 1'b0);
      check_eq($sformatf("d%0d %s wr_en", d, tag), wr_en[d], '0);
      check_eq($sformatf("d%0d %s loaded", d, tag), loaded[d], 1'b0);
      check_eq($sformatf("d%0d %s busy", d, tag), busy[d], exp_busy);
   endtask

   task automatic run_tile(input int d, input int base, input int nr, input int ddelay);
      int n;
      int lat;
      n   = (nr > FW) ? FW : nr;
      lat = lat_of(d);
      @(negedge clk);
      start[d]  = 1'b1;
      base_a[d] = AW'(base);
      nrows[d]  = RCW'(nr);
      for (int rel = 1; rel <= FW + lat + 3; rel++) begin
         @(negedge clk);
         start[d]       = 1'b0;
         drain_start[d] = 1'b0;
         check_cycle(d, rel, base, n);
         if (rel == 4) begin
            start[d]  = 1'b1;
            base_a[d] = ~AW'(base);
            nrows[d]  = RCW'($urandom_range(0, 16));
         end
         if (rel == 6) drain_start[d] = 1'b1;
         if (rel == FW + lat + 2) start[d] = 1'b1;
      end
      @(negedge clk);
      check_eq($sformatf("d%0d pre-drain loaded", d), loaded[d], 1'b1);
      drain_start[d] = 1'b1;
      @(negedge clk);
      drain_start[d] = 1'b0;
      drain_done[d]  = 1'b0;
      check_quiet(d, "drain1", 1'b1);
      for (int i = 2; i <= ddelay; i++) begin
         @(negedge clk);
         check_quiet(d, "drain", 1'b1);
      end
      @(negedge clk);
      drain_done[d] = 1'b1;
      check_quiet(d, "drain_last", 1'b1);
      @(negedge clk);
      check_quiet(d, "idle", 1'b0);
   endtask

   task automatic check_reset_state(input int d, input string tag);
      check_quiet(d, tag, 1'b0);
      check_eq($sformatf("d%0d %s addr", d, tag), addr[d], '0);
      check_eq($sformatf("d%0d %s wr_data", d, tag), wr_data[d], '0);
   endtask

   task automatic reset_mid(input int d, input int base);
      @(negedge clk);
      start[d]  = 1'b1;
      base_a[d] = AW'(base);
      nrows[d]  = RCW'(FW);
      for (int rel = 1; rel <= 8; rel++) begin
         @(negedge clk);
         start[d] = 1'b0;
         check_cycle(d, rel, base, FW);
      end
      rst[d]   = 1'b1;
      start[d] = 1'b1;
      @(negedge clk);
      rst[d]   = 1'b0;
      start[d] = 1'b0;
      check_reset_state(d, "after_reset");
      for (int i = 0; i < FW + 6; i++) begin
         @(negedge clk);
         check_quiet(d, "post_reset", 1'b0);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         logic [RW-1:0] row;
         row = '0;
         for (int w = 0; w < (RW + 31) / 32; w++) row = (row << 32) | RW'($urandom);
         mem[i] = row | RW'(1);
      end
      for (int d = 0; d < 2; d++) begin
         rst[d]         = 1'b1;
         start[d]       = 1'b0;
         base_a[d]      = '0;
         nrows[d]       = '0;
         drain_start[d] = 1'b0;
         drain_done[d]  = 1'b1;
      end
      repeat (3) @(negedge clk);
      check_reset_state(0, "reset");
      check_reset_state(1, "reset");
      rst[0] = 1'b0;
      rst[1] = 1'b0;

      run_tile(0, 'h10, 16, 2);
      run_tile(0, 'hFE, 5, 1);
      run_tile(0, $urandom_range(0, 255), 9, 31);
      run_tile(0, 'h40, 0, 1);
      run_tile(1, 'h40, 0, 1);
      reset_mid(1, 'h30);
      run_tile(1, 'h80, 16, 3);
      run_tile(1, 'hF8, 31, 2);
      run_tile(0, 'h20, 4, 1);
      run_tile(1, 'h20, 4, 1);
      for (int t = 0; t < 8; t++) begin
         run_tile($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 20), $urandom_range(1, 6));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/weight_fifo_fill.md
Name: weight_fifo_fill

Overview:
Write-side controller for the per-column weight FIFOs in front of the systolic array. On a `start` pulse it reads a weight tile row by row from weight memory and pushes exactly FIFO_WIDTH rows into the FIFOs. Rows beyond `num_rows` are pushed as zeros. It then holds the tile as loaded until the drain-side FIFO controller has flushed it, and only then accepts the next `start`.

Parameters:
FIFO_WIDTH, 16, number of FIFO lanes and rows per tile.
DATA_WIDTH, 8, bits per weight element.
ADDR_WIDTH, 8, weight memory address width.
MEM_LATENCY, 1, cycles from `mem_rd_en` to valid `mem_rd_data`; must be >= 1.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request to load a tile; sampled only in IDLE
base_addr  input  ADDR_WIDTH  address of tile row 0; captured on accepted `start`
num_rows  input  $clog2(FIFO_WIDTH)+1  valid rows in the tile; captured on accepted `start`
mem_rd_en  output  1  weight memory read strobe
mem_addr  output  ADDR_WIDTH  weight memory read address
mem_rd_data  input  FIFO_WIDTH*DATA_WIDTH  one row of weights, lane 0 in the LSBs
fifo_wr_en  output  FIFO_WIDTH  per-lane push; all bits always equal
fifo_wr_data  output  FIFO_WIDTH*DATA_WIDTH  row being pushed
drain_start  input  1  pulse, same signal that drives the drain controller's `active`
drain_done  input  1  drain controller `done` (high when idle)
loaded  output  1  full tile resident in the FIFOs, not yet drained
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE, slot counter 0, latency pipeline cleared.
  - Output values at reset: mem_rd_en=0, mem_addr=0, fifo_wr_en=0, fifo_wr_data=0, loaded=0, busy=0.
- FSM states: IDLE, ISSUE, WAIT, LOADED, DRAIN.
- IDLE:
  - On `start`=1, capture `base_addr` and n=min(num_rows, FIFO_WIDTH), clear slot counter k, go to ISSUE.
  - `start` in any other state is ignored; it is not queued.
- ISSUE lasts exactly FIFO_WIDTH cycles, k=0..FIFO_WIDTH-1:
  - When k<n: mem_rd_en=1, mem_addr=(base+k) mod 2^ADDR_WIDTH.
  - When k>=n: mem_rd_en=0 and mem_addr holds its last value.
  - Each slot enters a MEM_LATENCY-deep pipeline carrying valid=1 and real=(k<n).
  - Leave ISSUE after k=FIFO_WIDTH-1, going to WAIT.
- Push timing: a slot issued in cycle t is pushed in cycle t+MEM_LATENCY.
  - fifo_wr_en is all ones in that cycle.
  - fifo_wr_data = mem_rd_data if real, else 0.
  - Outside push cycles: fifo_wr_en=0 and fifo_wr_data=0.
- WAIT: stay until the pipeline is empty, i.e. MEM_LATENCY cycles after leaving ISSUE, then go to LOADED.
  - Exactly FIFO_WIDTH pushes occur per tile.
- Timing from `start` sampled at cycle 0:
  - First read at cycle 1, first push at cycle 1+MEM_LATENCY.
  - Last push at cycle FIFO_WIDTH+MEM_LATENCY.
  - `loaded` first high at cycle FIFO_WIDTH+MEM_LATENCY+1.
- LOADED: loaded=1. On `drain_start`=1, go to DRAIN.
- DRAIN: loaded=0. Go to IDLE in the first cycle where `drain_done`=1.
  - `drain_done` is not checked in the cycle `drain_start` is seen. This ignores the stale idle-high value.
- `drain_start` outside LOADED is ignored.
- num_rows=0: no memory reads, FIFO_WIDTH zero rows pushed, normal completion.
- num_rows>FIFO_WIDTH: clamped to FIFO_WIDTH.
- Address wrap past 2^ADDR_WIDTH-1 wraps to 0 silently.
- Reset mid-operation (any state): return to IDLE next cycle.
  - In-flight pipeline entries are discarded; no further pushes.
  - Partial FIFO contents are the owner's responsibility to flush.
- When reset and start are both high in the same cycle, reset wins.

Optional Feature:
- Macro: WEIGHT_FILL_REVERSE_EN.
- Defined: for k<n, mem_addr=(base+n-1-k) mod 2^ADDR_WIDTH.
  - Tile rows are pushed last-row-first; zero-pad slots still come last.
  - Timing and all other behaviour are unchanged.
- Undefined: ascending order as specified above.

Decomposition:
- Shared package `tpu_ctrl_pkg`:
  - fill FSM state enum;
  - `ROW_COUNT_WIDTH` = $clog2(FIFO_WIDTH)+1;
  - row-bus width helper FIFO_WIDTH*DATA_WIDTH.
- One natural sub-module: `valid_delay_line`, a parameterised MEM_LATENCY-deep shift register of {valid, real} bits with synchronous clear.

Test Plan:
1. Tile with n=FIFO_WIDTH:
   - Stimulus: MEM_LATENCY=1, start with base=0x10, num_rows=16.
   - Required: reads at 0x10..0x1F in cycles 1..16; 16 pushes in cycles 2..17 matching memory rows; loaded=1 from cycle 18.
2. Zero padding:
   - Stimulus: num_rows=5, base=0xFE, ADDR_WIDTH=8.
   - Required: reads 0xFE, 0xFF, 0x00, 0x01, 0x02; 5 data pushes followed by 11 all-zero pushes.
3. Handshake:
   - Stimulus: in LOADED, pulse drain_start; hold drain_done=0 for 31 cycles, then 1.
   - Required: loaded drops the cycle after drain_start; busy stays high; IDLE reached the cycle after drain_done=1.
4. Ignored requests and num_rows=0:
   - Stimulus: pulse start during ISSUE and LOADED.
   - Required: no extra reads or pushes.
   - Stimulus: num_rows=0.
   - Required: mem_rd_en never high; 16 zero pushes.
5. Reset mid-operation:
   - Stimulus: MEM_LATENCY=3; assert reset at slot k=7.
   - Required: no fifo_wr_en after reset; all outputs 0 the next cycle.
   - Stimulus: a new start afterwards.
   - Required: a clean full tile.
6. With WEIGHT_FILL_REVERSE_EN:
   - Stimulus: n=4, base=0x20.
   - Required: reads 0x23, 0x22, 0x21, 0x20, then 12 zero pushes.
